// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon plaintext packer: rate constants, the
// padded-length derivation and the packer FSM states.
package ascon_pkg;

  localparam int unsigned ASCON_RATE_BYTES = 8;
  localparam logic [7:0]  PAD_BYTE         = 8'h80;

  // Padding always adds at least one byte, so an aligned payload gets a full block.
  function automatic int unsigned pt_bytes_f(input int unsigned data_bytes);
    return ASCON_RATE_BYTES * ((data_bytes + ASCON_RATE_BYTES) / ASCON_RATE_BYTES);
  endfunction

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    PAD      = 2'd1,
    START    = 2'd2,
    WAIT_END = 2'd3
  } packer_state_t;

endpackage

// File: rtl/ascon_plaintext_packer_if.sv
// Byte-stream input and cipher-side frame/handshake bus of the plaintext packer.
interface ascon_plaintext_packer_if #(
  parameter int unsigned PT_BYTES = 184
);

  logic [7:0]            byte_i;
  logic                  byte_valid_i;
  logic                  byte_ready_o;
  logic                  end_ascon_i;
  logic [8*PT_BYTES-1:0] plain_text_o;
  logic                  start_o;
  logic                  busy_o;

  modport master (
    output byte_i, byte_valid_i, end_ascon_i,
    input  byte_ready_o, plain_text_o, start_o, busy_o
  );

  modport slave (
    input  byte_i, byte_valid_i, end_ascon_i,
    output byte_ready_o, plain_text_o, start_o, busy_o
  );

endinterface

// File: rtl/ascon_plaintext_packer.sv
// Packs a payload byte stream into one padded Ascon plaintext frame, pulses
// start to the cipher core and holds the frame until completion is reported.
module ascon_plaintext_packer
  import ascon_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 181,
  parameter int unsigned PT_BYTES   = pt_bytes_f(DATA_BYTES)
) (
  input logic                     clock_i,
  input logic                     reset_i,
  ascon_plaintext_packer_if.slave pk
);

  localparam int unsigned CW = $clog2(PT_BYTES + 1);
  localparam logic [CW-1:0] LAST_DATA_CNT = CW'(DATA_BYTES - 1);
  localparam logic [CW-1:0] DATA_CNT      = CW'(DATA_BYTES);
  localparam logic [CW-1:0] LAST_PT_CNT   = CW'(PT_BYTES - 1);

  packer_state_t         state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [8*PT_BYTES-1:0] frame_q, frame_d;
  logic                  shift_en;
  logic [7:0]            shift_byte;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    shift_en   = 1'b0;
    shift_byte = '0;
    case (state_q)
      COLLECT: begin
        if (pk.byte_valid_i) begin
          shift_en   = 1'b1;
          shift_byte = pk.byte_i;
          cnt_d      = cnt_q + CW'(1);
          if (cnt_q == LAST_DATA_CNT) state_d = PAD;
        end
      end
      PAD: begin
        // The count still equals DATA_BYTES only on the first padding cycle.
        shift_en   = 1'b1;
        shift_byte = (cnt_q == DATA_CNT) ? PAD_BYTE : 8'h00;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == LAST_PT_CNT) state_d = START;
      end
      START: state_d = WAIT_END;
      WAIT_END: begin
        if (pk.end_ascon_i) begin
          cnt_d   = '0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
    if (shift_en) frame_d = {frame_q[8*PT_BYTES-9:0], shift_byte};
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  // Handshake outputs are suppressed while reset is asserted.
  assign pk.byte_ready_o = (state_q == COLLECT) && !reset_i;
  assign pk.start_o      = (state_q == START) && !reset_i;
  assign pk.busy_o       = (state_q != COLLECT) && !reset_i;
  assign pk.plain_text_o = frame_q;

endmodule

// File: tb/tb_ascon_plaintext_packer.sv
// Self-checking bench for ascon_plaintext_packer: default frame size plus a
// DATA_BYTES=8 instance, checked against a byte-array frame model.
module tb_ascon_plaintext_packer;

  localparam int unsigned D   = 181;
  localparam int unsigned PT  = 8 * ((D + 8) / 8);
  localparam int unsigned CD  = 8;
  localparam int unsigned CPT = 8 * ((CD + 8) / 8);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ascon_plaintext_packer_if #(.PT_BYTES(PT))  pif ();
  ascon_plaintext_packer_if #(.PT_BYTES(CPT)) cif ();

  ascon_plaintext_packer #(.DATA_BYTES(D), .PT_BYTES(PT)) dut (
    .clock_i(clk), .reset_i(rst), .pk(pif)
  );
  ascon_plaintext_packer #(.DATA_BYTES(CD), .PT_BYTES(CPT)) cdut (
    .clock_i(clk), .reset_i(rst), .pk(cif)
  );

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int acc_cnt = 0, start_cnt = 0, last_acc = 0, start_cyc = 0;
  int cacc_cnt = 0, cstart_cnt = 0, clast_acc = 0, cstart_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pif.byte_valid_i && pif.byte_ready_o) begin
      acc_cnt  <= acc_cnt + 1;
      last_acc <= cyc;
    end
    if (pif.start_o) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (cif.byte_valid_i && cif.byte_ready_o) begin
      cacc_cnt  <= cacc_cnt + 1;
      clast_acc <= cyc;
    end
    if (cif.start_o) begin
      cstart_cnt <= cstart_cnt + 1;
      cstart_cyc <= cyc;
    end
  end

  logic [7:0] payload [D];
  logic [7:0] ref_payload [D];

  // Expected frame: payload bytes in order from the MSB end, then 0x80, then zeros.
  function automatic logic [8*PT-1:0] model_frame();
    logic [8*PT-1:0] v;
    logic [7:0] b;
    v = '0;
    for (int i = 0; i < int'(PT); i++) begin
      if (i < int'(D)) b = payload[i];
      else if (i == int'(D)) b = 8'h80;
      else b = 8'h00;
      v[8*(int'(PT)-1-i) +: 8] = b;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_end();
    pif.byte_valid_i = 1'b0;
    pif.end_ascon_i  = 1'b1;
    tick();
    pif.end_ascon_i  = 1'b0;
  endtask

  task automatic send_payload(input int n, input int max_gap, input bit keep_aa, input int spur_idx);
    int w;
    for (int i = 0; i < n; i++) begin
      if (max_gap > 0) begin
        pif.byte_valid_i = 1'b0;
        repeat ($urandom_range(0, max_gap)) tick();
      end
      pif.byte_valid_i = 1'b1;
      pif.byte_i       = payload[i];
      pif.end_ascon_i  = (i == spur_idx);
      w = 0;
      while (!pif.byte_ready_o && w < 100) begin
        tick();
        w++;
      end
      checks++;
      if (w >= 100) begin
        errors++;
        $display("FAIL ready_timeout: byte %0d never accepted (ready=%b, required 1)", i, pif.byte_ready_o);
      end
      tick();
      pif.end_ascon_i = 1'b0;
      if (i == spur_idx) begin
        checks++;
        if (pif.busy_o !== 1'b0 || pif.byte_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL spurious_collect: busy=%b ready=%b, required busy=0 ready=1", pif.busy_o, pif.byte_ready_o);
        end
      end
    end
    pif.byte_valid_i = keep_aa;
    pif.byte_i       = keep_aa ? 8'hAA : 8'h00;
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (pif.start_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL start_timeout: start_o=%b after 40 cycles, required 1", pif.start_o);
    end
  endtask

  task automatic check_frame(input string name);
    logic [8*PT-1:0] e;
    e = model_frame();
    checks++;
    if (pif.plain_text_o !== e) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, pif.plain_text_o, e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pif.byte_valid_i = 1'b0; pif.byte_i = '0; pif.end_ascon_i = 1'b0;
    cif.byte_valid_i = 1'b0; cif.byte_i = '0; cif.end_ascon_i = 1'b0;
    tick();
    tick();
    checks++;
    if (pif.byte_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b required 0", pif.byte_ready_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (pif.plain_text_o !== '0 || pif.start_o !== 1'b0 || pif.busy_o !== 1'b0 || pif.byte_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: start=%b busy=%b ready=%b frame_nonzero=%b, required 0 0 1 0",
               pif.start_o, pif.busy_o, pif.byte_ready_o, |pif.plain_text_o);
    end
    checks++;
    if (cif.plain_text_o !== '0) begin
      errors++;
      $display("FAIL reset_corner_frame: got %h required 0", cif.plain_text_o);
    end
  endtask

  task automatic test_reference();
    bit seen;
    int s0;
    for (int i = 0; i < int'(D); i++) payload[i] = 8'($urandom);
    payload[0] = 8'h5A; payload[1] = 8'h5B; payload[2] = 8'h5B;
    payload[D-3] = 8'h54; payload[D-2] = 8'h52; payload[D-1] = 8'h52;
    for (int i = 0; i < int'(D); i++) ref_payload[i] = payload[i];
    s0 = start_cnt;
    send_payload(D, 0, 1'b0, -1);
    wait_start(seen);
    check_frame("reference_frame");
    checks++;
    if (pif.plain_text_o[39:0] !== 40'h52_52_80_00_00) begin
      errors++;
      $display("FAIL reference_tail: got %h required 5252800000", pif.plain_text_o[39:0]);
    end
    tick();
    checks++;
    if (start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL reference_start_count: got %0d required 1", start_cnt - s0);
    end
    checks++;
    if (start_cyc - last_acc != 4) begin
      errors++;
      $display("FAIL reference_latency: got %0d required 4", start_cyc - last_acc);
    end
    checks++;
    if (pif.busy_o !== 1'b1 || pif.start_o !== 1'b0) begin
      errors++;
      $display("FAIL reference_wait: busy=%b start=%b, required 1 0", pif.busy_o, pif.start_o);
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    int a0;
    a0 = acc_cnt;
    pif.byte_valid_i = 1'b1;
    pif.byte_i       = 8'hAA;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pif.byte_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_wait_ready: got %b required 0", pif.byte_ready_o);
      end
      tick();
    end
    pulse_end();
    checks++;
    if (pif.byte_ready_o !== 1'b1 || acc_cnt != a0) begin
      errors++;
      $display("FAIL bp_release: ready=%b accepts=%0d, required 1 0", pif.byte_ready_o, acc_cnt - a0);
    end
    check_frame("bp_frame_held");
    for (int i = 0; i < int'(D); i++) payload[i] = 8'(i + 1);
    a0 = acc_cnt;
    send_payload(D, 0, 1'b1, -1);
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (pif.byte_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready_low: cycle %0d got %b required 0", k, pif.byte_ready_o);
      end
      tick();
    end
    check_frame("bp_second_frame");
    checks++;
    if (acc_cnt - a0 != int'(D)) begin
      errors++;
      $display("FAIL bp_accepts: got %0d required %0d", acc_cnt - a0, D);
    end
    pulse_end();
    checks++;
    if (pif.byte_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_next: got %b required 1", pif.byte_ready_o);
    end
    seen = 1'b0;
  endtask

  task automatic test_valid_gaps();
    bit seen;
    int a0;
    for (int i = 0; i < int'(D); i++) payload[i] = ref_payload[i];
    a0 = acc_cnt;
    send_payload(D, 5, 1'b0, -1);
    wait_start(seen);
    check_frame("gaps_frame");
    checks++;
    if (acc_cnt - a0 != int'(D)) begin
      errors++;
      $display("FAIL gaps_accepts: got %0d required %0d", acc_cnt - a0, D);
    end
    tick();
    pulse_end();
  endtask

  task automatic test_spurious();
    bit seen;
    int s0;
    for (int i = 0; i < int'(D); i++) payload[i] = 8'($urandom);
    s0 = start_cnt;
    send_payload(D, 0, 1'b0, 37);
    wait_start(seen);
    pif.end_ascon_i = 1'b1;
    tick();
    pif.end_ascon_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (pif.busy_o !== 1'b1 || pif.byte_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL spurious_start_end: busy=%b ready=%b, required 1 0", pif.busy_o, pif.byte_ready_o);
      end
      tick();
    end
    check_frame("spurious_frame");
    checks++;
    if (start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL spurious_start_count: got %0d required 1", start_cnt - s0);
    end
    pulse_end();
    checks++;
    if (pif.byte_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL spurious_release: got %b required 1", pif.byte_ready_o);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int s0;
    for (int i = 0; i < int'(D); i++) payload[i] = 8'($urandom);
    s0 = start_cnt;
    send_payload(100, 0, 1'b0, -1);
    rst = 1'b1;
    #1;
    checks++;
    if (pif.byte_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ready: got %b required 0", pif.byte_ready_o);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (pif.plain_text_o !== '0 || pif.busy_o !== 1'b0 || pif.byte_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state: busy=%b ready=%b frame_nonzero=%b, required 0 1 0",
               pif.busy_o, pif.byte_ready_o, |pif.plain_text_o);
    end
    repeat (10) tick();
    checks++;
    if (start_cnt != s0) begin
      errors++;
      $display("FAIL midreset_no_start: got %0d pulses required 0", start_cnt - s0);
    end
    for (int i = 0; i < int'(D); i++) payload[i] = 8'h11;
    send_payload(D, 0, 1'b0, -1);
    wait_start(seen);
    check_frame("midreset_refill");
    tick();
    pulse_end();
  endtask

  task automatic test_corner();
    int w;
    int s0;
    s0 = cstart_cnt;
    for (int i = 0; i < int'(CD); i++) begin
      cif.byte_valid_i = 1'b1;
      cif.byte_i       = 8'(i + 1);
      w = 0;
      while (!cif.byte_ready_o && w < 100) begin
        tick();
        w++;
      end
      tick();
    end
    cif.byte_valid_i = 1'b0;
    w = 0;
    while (cif.start_o !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    checks++;
    if (cif.plain_text_o !== 128'h0102030405060708_8000000000000000) begin
      errors++;
      $display("FAIL corner_frame: got %h required 01020304050607088000000000000000", cif.plain_text_o);
    end
    tick();
    checks++;
    if (cstart_cnt - s0 != 1 || cstart_cyc - clast_acc != 9) begin
      errors++;
      $display("FAIL corner_latency: starts=%0d latency=%0d, required 1 9", cstart_cnt - s0, cstart_cyc - clast_acc);
    end
    cif.end_ascon_i = 1'b1;
    tick();
    cif.end_ascon_i = 1'b0;
    checks++;
    if (cif.byte_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL corner_release: got %b required 1", cif.byte_ready_o);
    end
  endtask

  initial begin
    test_reset();
    test_reference();
    test_backpressure();
    test_valid_gaps();
    test_spurious();
    test_reset_mid();
    test_corner();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ascon_plaintext_packer.md
Name: ascon_plaintext_packer

Overview:
- Upstream stage of ascon_fsm: collects a byte stream of sensor samples, such as ECG bytes from a UART receiver, into one Ascon plaintext frame.
- Appends Ascon padding (0x80, then 0x00 up to the 64-bit boundary).
- Presents the frame as a flat bus, pulses start for one cycle, then waits for the cipher core to finish before accepting the next frame.

Parameters:
- DATA_BYTES, 181: payload bytes per frame.
- PT_BYTES, 184: padded frame length in bytes. Equals 8*((DATA_BYTES+8)/8) with integer division. Default gives 1472 bits (23 x 64-bit blocks).

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- byte_i  in  8  payload byte.
- byte_valid_i  in  1  byte_i is valid this cycle.
- byte_ready_o  out  1  packer accepts a byte this cycle.
- end_ascon_i  in  1  completion pulse from ascon_fsm.
- plain_text_o  out  8*PT_BYTES  padded frame; first received byte in bits [8*PT_BYTES-1 -: 8].
- start_o  out  1  one-cycle start pulse to ascon_fsm.
- busy_o  out  1  high from the first padding cycle until end_ascon_i is seen.

Behaviour:
- Reset (sampled on the clock edge while reset_i=1) applies to all state:
  - state=COLLECT, byte count=0, frame register=0.
  - byte_ready_o=0 during the reset cycle. After reset it follows the state rules below.
  - start_o=0, busy_o=0, plain_text_o=0.
- Reset mid-operation, in any state: abandons the frame and returns to COLLECT with count 0. No start_o is issued.
- Frame register:
  - Is a shift register. Each write does reg <= {reg[8*PT_BYTES-9:0], new_byte}.
  - After PT_BYTES writes, the first byte sits at the MSB end.
- COLLECT:
  - byte_ready_o=1.
  - A transfer happens only when byte_valid_i and byte_ready_o are both 1. On a transfer, shift in byte_i and increment count.
  - When the transfer that makes count==DATA_BYTES occurs, move to PAD next cycle.
  - byte_valid_i=0 holds state; there is no timeout.
- PAD:
  - byte_ready_o=0, busy_o=1.
  - First PAD cycle shifts in 0x80. Each later PAD cycle shifts in 0x00.
  - One byte per cycle until count==PT_BYTES, then move to START.
  - With defaults: 3 PAD cycles.
- START:
  - start_o=1 for exactly this one cycle, busy_o=1, byte_ready_o=0.
  - Next state is WAIT_END.
- Latency with defaults: last payload byte accepted at edge t → start_o high in the cycle after edge t+3.
- WAIT_END:
  - busy_o=1, byte_ready_o=0.
  - On end_ascon_i=1: clear count, go to COLLECT. byte_ready_o=1 from the next cycle.
- plain_text_o stability: held stable from START until the first byte of the next frame is accepted. ascon_fsm may sample it at any time in that window.
- end_ascon_i outside WAIT_END is ignored.
- end_ascon_i in the same cycle as start_o is ignored; the packer waits for a later pulse.
- Count width: $clog2(PT_BYTES+1). Count never exceeds PT_BYTES and never wraps.
- Edge case DATA_BYTES a multiple of 8: padding is a full 8 bytes (0x80 followed by 7 x 0x00).

Decomposition:
- Shared package ascon_pkg holds:
  - localparams ASCON_RATE_BYTES=8, PAD_BYTE=8'h80.
  - The PT_BYTES derivation function.
  - State enum packer_state_t {COLLECT, PAD, START, WAIT_END}.
- No sub-module: a single FSM plus shift register plus counter.

Test Plan:
- Reference frame:
  - Stimulus: stream the 181 bytes 5A,5B,5B,...,54,52,52 back-to-back with valid held high.
  - Response: plain_text_o equals the 1472-bit vector ending _52_52_80_00_00. start_o pulses once, 4 cycles after the last accept. busy_o=1 afterwards.
- Valid gaps:
  - Stimulus: same frame with byte_valid_i deasserted for random 0–5 cycle gaps.
  - Response: identical plain_text_o, and exactly 181 accepts counted.
- Backpressure:
  - Stimulus: during PAD/START/WAIT_END, drive valid=1 with byte 0xAA.
  - Response: byte_ready_o=0 and no 0xAA appears in the frame.
  - Stimulus: then pulse end_ascon_i.
  - Response: byte_ready_o=1 on the next cycle, and a second frame of 0x01..0xB5 packs correctly.
- Spurious completion:
  - Stimulus: end_ascon_i pulses during COLLECT, and again in the start_o cycle.
  - Response: both are ignored; the state stays as it was.
- Reset mid-frame:
  - Stimulus: reset_i=1 for 1 cycle after 100 bytes.
  - Response: plain_text_o=0 and no start_o. A following full frame of 181 x 0x11 yields 0x11...11_80_00_00.
- Parameter corner:
  - Stimulus: DATA_BYTES=8 with bytes 01..08.
  - Response: PT_BYTES=16, plain_text_o=128'h0102030405060708_8000000000000000, and 8 PAD cycles before start_o.
